mic1_mem_ctrl: RTL and testbench



---
 rtl/mic1_mem_pkg.sv | 29 ++
 rtl/mic1_byte_lane.sv | 18 +
 rtl/mic1_mem_ctrl.sv | 186 ++++++++++++++++++
 tb/tb_mic1_mem_ctrl.sv | 175 +++++++++++++++++
 4 files changed

// File: rtl/mic1_mem_pkg.sv
// Shared types for the MIC-1 memory sequencer: FSM encoding, data widths and
// the layout of the two pending-request slots.
package mic1_mem_pkg;

  localparam int DATA_W      = 32;
  localparam int BYTE_W      = 8;
  localparam int SLOT_ADDR_W = 32;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DATA  = 2'd1,
    FETCH = 2'd2
  } state_t;

  // Slot addresses are stored zero-extended; only the low ADDR_W bits reach the port.
  typedef struct packed {
    logic                   valid;
    logic                   we;
    logic [SLOT_ADDR_W-1:0] addr;
    logic [DATA_W-1:0]      wdata;
  } data_slot_t;

  typedef struct packed {
    logic                   valid;
    logic [SLOT_ADDR_W-1:0] addr;
    logic [1:0]             offset;
  } fetch_slot_t;

endpackage

// File: rtl/mic1_byte_lane.sv
// Little-endian byte extraction from a 32-bit memory word.
module mic1_byte_lane
  import mic1_mem_pkg::*;
(
  input  logic [DATA_W-1:0] word,
  input  logic [1:0]        offset,
  output logic [BYTE_W-1:0] lane_byte
);

  logic [BYTE_W-1:0] lanes [4];

  for (genvar gi = 0; gi < 4; gi++) begin : g_lane
    assign lanes[gi] = word[gi*BYTE_W +: BYTE_W];
  end

  assign lane_byte = lanes[offset];

endmodule

// File: rtl/mic1_mem_ctrl.sv
// MIC-1 memory sequencer: queues one data access and one instruction fetch and
// arbitrates them onto a single-port word memory with a req/ack handshake.
module mic1_mem_ctrl
  import mic1_mem_pkg::*;
#(
  parameter int ADDR_W     = 16,
  parameter int STARVE_MAX = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              rd_req,
  input  logic              wr_req,
  input  logic              fetch_req,
  input  logic [31:0]       mar,
  input  logic [31:0]       mdr_wdata,
  input  logic [31:0]       pc,
  output logic [31:0]       mdr_rdata,
  output logic              mdr_load,
  output logic [7:0]        mbr_data,
  output logic              mbr_load,
  output logic              stall,
  output logic              err,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  input  logic [31:0]       mem_rdata,
  input  logic              mem_ack
);

  localparam int CNT_W = (STARVE_MAX < 1) ? 1 : $clog2(STARVE_MAX + 1);
  localparam logic [CNT_W-1:0] STARVE_LIM = CNT_W'(STARVE_MAX);

  state_t            state_reg, state_next;
  data_slot_t        data_slot_reg, data_slot_next;
  fetch_slot_t       fetch_slot_reg, fetch_slot_next;
  logic [CNT_W-1:0]  starve_cnt_reg, starve_cnt_next;

  logic              mem_req_reg, mem_req_next;
  logic              mem_we_reg, mem_we_next;
  logic [ADDR_W-1:0] mem_addr_reg, mem_addr_next;
  logic [31:0]       mem_wdata_reg, mem_wdata_next;
  logic [31:0]       mdr_rdata_reg, mdr_rdata_next;
  logic              mdr_load_reg, mdr_load_next;
  logic [7:0]        mbr_data_reg, mbr_data_next;
  logic              mbr_load_reg, mbr_load_next;
  logic              err_reg, err_next;

  logic              data_strobe, data_ack, fetch_ack, data_busy, fetch_busy;
  logic              grant_point, grant_data, grant_fetch, data_first;
  logic [BYTE_W-1:0] lane_byte;
  logic              unused_addr_bits;

  assign unused_addr_bits = ^{mar[31:ADDR_W], pc[31:ADDR_W+2]};

  assign data_strobe = rd_req | wr_req;
  assign data_ack    = (state_reg == DATA) && mem_ack;
  assign fetch_ack   = (state_reg == FETCH) && mem_ack;
  // A slot being acknowledged this cycle counts as free so it can be refilled at once.
  assign data_busy   = data_slot_reg.valid && !data_ack;
  assign fetch_busy  = fetch_slot_reg.valid && !fetch_ack;

  always_comb begin
    data_slot_next = data_slot_reg;
    if (data_ack) data_slot_next.valid = 1'b0;
    if (data_strobe && !data_busy) begin
      data_slot_next.valid = 1'b1;
      data_slot_next.we    = wr_req;
      data_slot_next.addr  = SLOT_ADDR_W'(mar[ADDR_W-1:0]);
      data_slot_next.wdata = mdr_wdata;
    end
  end

  always_comb begin
    fetch_slot_next = fetch_slot_reg;
    if (fetch_ack) fetch_slot_next.valid = 1'b0;
    if (fetch_req && !fetch_busy) begin
      fetch_slot_next.valid  = 1'b1;
      fetch_slot_next.addr   = SLOT_ADDR_W'(pc[ADDR_W+1:2]);
      fetch_slot_next.offset = pc[1:0];
    end
  end

  mic1_byte_lane u_byte_lane (
    .word      (mem_rdata),
    .offset    (fetch_slot_reg.offset),
    .lane_byte (lane_byte)
  );

  // FSM: state register
  always_ff @(posedge clk) begin
    if (rst) state_reg <= IDLE;
    else     state_reg <= state_next;
  end

  // FSM: next state. Arbitration looks at the slot contents as they will be
  // after this edge, so a same-cycle capture or refill is granted immediately.
  assign grant_point = ((state_reg != DATA) && (state_reg != FETCH)) || mem_ack;
  assign data_first  = !fetch_slot_next.valid || (starve_cnt_reg < STARVE_LIM);

  always_comb begin
    state_next  = state_reg;
    grant_data  = 1'b0;
    grant_fetch = 1'b0;
    if (grant_point) begin
      if (data_slot_next.valid && data_first) begin
        state_next = DATA;
        grant_data = 1'b1;
      end else if (fetch_slot_next.valid) begin
        state_next  = FETCH;
        grant_fetch = 1'b1;
      end else begin
        state_next = IDLE;
      end
    end
  end

  // FSM: outputs (next values of the registered port signals)
  always_comb begin
    mem_req_next    = (state_next != IDLE);
    mem_we_next     = mem_we_reg;
    mem_addr_next   = mem_addr_reg;
    mem_wdata_next  = mem_wdata_reg;
    starve_cnt_next = starve_cnt_reg;
    if (grant_data) begin
      mem_we_next    = data_slot_next.we;
      mem_addr_next  = data_slot_next.addr[ADDR_W-1:0];
      mem_wdata_next = data_slot_next.wdata;
      if (fetch_slot_next.valid && (starve_cnt_reg < STARVE_LIM))
        starve_cnt_next = starve_cnt_reg + 1'b1;
    end else if (grant_fetch) begin
      mem_we_next     = 1'b0;
      mem_addr_next   = fetch_slot_next.addr[ADDR_W-1:0];
      mem_wdata_next  = '0;
      starve_cnt_next = '0;
    end
    mdr_load_next  = data_ack && !data_slot_reg.we;
    mdr_rdata_next = mdr_load_next ? mem_rdata : mdr_rdata_reg;
    mbr_load_next  = fetch_ack;
    mbr_data_next  = fetch_ack ? lane_byte : mbr_data_reg;
    err_next       = err_reg | (rd_req & wr_req) | (mem_ack & ~mem_req_reg);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      data_slot_reg  <= '0;
      fetch_slot_reg <= '0;
      starve_cnt_reg <= '0;
      mem_req_reg    <= 1'b0;
      mem_we_reg     <= 1'b0;
      mem_addr_reg   <= '0;
      mem_wdata_reg  <= '0;
      mdr_rdata_reg  <= '0;
      mdr_load_reg   <= 1'b0;
      mbr_data_reg   <= '0;
      mbr_load_reg   <= 1'b0;
      err_reg        <= 1'b0;
    end else begin
      data_slot_reg  <= data_slot_next;
      fetch_slot_reg <= fetch_slot_next;
      starve_cnt_reg <= starve_cnt_next;
      mem_req_reg    <= mem_req_next;
      mem_we_reg     <= mem_we_next;
      mem_addr_reg   <= mem_addr_next;
      mem_wdata_reg  <= mem_wdata_next;
      mdr_rdata_reg  <= mdr_rdata_next;
      mdr_load_reg   <= mdr_load_next;
      mbr_data_reg   <= mbr_data_next;
      mbr_load_reg   <= mbr_load_next;
      err_reg        <= err_next;
    end
  end

  // Held off while the port is busy so the control path re-presents the request.
  assign stall     = (data_strobe && data_busy) || (fetch_req && fetch_busy);
  assign mem_req   = mem_req_reg;
  assign mem_we    = mem_we_reg;
  assign mem_addr  = mem_addr_reg;
  assign mem_wdata = mem_wdata_reg;
  assign mdr_rdata = mdr_rdata_reg;
  assign mdr_load  = mdr_load_reg;
  assign mbr_data  = mbr_data_reg;
  assign mbr_load  = mbr_load_reg;
  assign err       = err_reg;

endmodule

// File: tb/tb_mic1_mem_ctrl.sv
// Directed-vector bench for mic1_mem_ctrl; the memory side is driven by hand.
module tb_mic1_mem_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        rd_req = 1'b0, wr_req = 1'b0, fetch_req = 1'b0;
  logic [31:0] mar = '0, mdr_wdata = '0, pc = '0, mem_rdata = '0;
  logic        mem_ack = 1'b0;
  logic [31:0] mdr_rdata, mem_wdata;
  logic        mdr_load, mbr_load, stall, err, mem_req, mem_we;
  logic [7:0]  mbr_data;
  logic [15:0] mem_addr;

  int tests_run = 0;
  int tests_failed = 0;

  always #5 clk = ~clk;

  mic1_mem_ctrl #(.ADDR_W(16), .STARVE_MAX(2)) dut (
    .clk(clk), .rst(rst), .rd_req(rd_req), .wr_req(wr_req), .fetch_req(fetch_req),
    .mar(mar), .mdr_wdata(mdr_wdata), .pc(pc), .mdr_rdata(mdr_rdata), .mdr_load(mdr_load),
    .mbr_data(mbr_data), .mbr_load(mbr_load), .stall(stall), .err(err),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_ack(mem_ack)
  );

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1; rd_req = 0; wr_req = 0; fetch_req = 0; mem_ack = 0;
    cyc();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; rd_req = 0; wr_req = 0; fetch_req = 0; mem_ack = 0;
    cyc(); cyc();
    tests_run++; if ({mem_req, mem_we, mem_addr, mem_wdata} !== '0) begin tests_failed++; $display("FAIL reset_mem: got req=%b we=%b addr=%h wdata=%h, expected all 0", mem_req, mem_we, mem_addr, mem_wdata); end
    tests_run++; if ({mdr_load, mdr_rdata, mbr_load, mbr_data} !== '0) begin tests_failed++; $display("FAIL reset_loads: got mdr_load=%b mdr=%h mbr_load=%b mbr=%h, expected all 0", mdr_load, mdr_rdata, mbr_load, mbr_data); end
    tests_run++; if ({err, stall} !== 2'b00) begin tests_failed++; $display("FAIL reset_flags: got err=%b stall=%b, expected 0 0", err, stall); end
    rst = 1'b0;
    $display("[TB] test_reset: outputs checked under rst");
  endtask

  task automatic test_read();
    do_reset();
    mar = 32'h10; rd_req = 1;                                   // cycle t
    cyc(); rd_req = 0;                                          // t+1
    tests_run++; if ({mem_req, mem_we, mem_addr} !== {1'b1, 1'b0, 16'h0010}) begin tests_failed++; $display("FAIL read_issue: got req=%b we=%b addr=%h, expected 1 0 0010", mem_req, mem_we, mem_addr); end
    cyc(); cyc(); cyc();                                        // t+4
    mem_ack = 1; mem_rdata = 32'hDEADBEEF; #1;
    tests_run++; if (mdr_load !== 1'b0) begin tests_failed++; $display("FAIL read_early_load: got %b expected 0", mdr_load); end
    cyc(); mem_ack = 0;                                         // t+5
    tests_run++; if ({mdr_load, mdr_rdata, mem_req} !== {1'b1, 32'hDEADBEEF, 1'b0}) begin tests_failed++; $display("FAIL read_load: got load=%b data=%h req=%b, expected 1 deadbeef 0", mdr_load, mdr_rdata, mem_req); end
    cyc();
    tests_run++; if (mdr_load !== 1'b0) begin tests_failed++; $display("FAIL read_load_pulse: got %b expected 0", mdr_load); end
    $display("[TB] test_read: mar=0x10 -> 0x%h", mdr_rdata);
  endtask

  task automatic test_fetch();
    logic [7:0] exp_b [4];
    exp_b = '{8'h11, 8'h22, 8'h33, 8'h44};
    do_reset();
    pc = 32'h6; fetch_req = 1;                                  // t
    cyc(); fetch_req = 0;                                       // t+1
    tests_run++; if ({mem_req, mem_we, mem_addr} !== {1'b1, 1'b0, 16'h0001}) begin tests_failed++; $display("FAIL fetch_issue: got req=%b we=%b addr=%h, expected 1 0 0001", mem_req, mem_we, mem_addr); end
    cyc(); mem_ack = 1; mem_rdata = 32'h44332211;               // t+2
    cyc(); mem_ack = 0;                                         // t+3
    tests_run++; if ({mbr_load, mbr_data, mdr_load} !== {1'b1, 8'h33, 1'b0}) begin tests_failed++; $display("FAIL fetch_load: got mbr_load=%b mbr=%h mdr_load=%b, expected 1 33 0", mbr_load, mbr_data, mdr_load); end
    cyc();
    tests_run++; if (mbr_load !== 1'b0) begin tests_failed++; $display("FAIL fetch_load_pulse: got %b expected 0", mbr_load); end
    $display("[TB] test_fetch: pc=0x6 -> 0x%h", mbr_data);
    for (int off = 0; off < 4; off++) begin
      pc = 32'h10 + 32'(off); fetch_req = 1;
      cyc(); fetch_req = 0;
      tests_run++; if (mem_addr !== 16'h0004) begin tests_failed++; $display("FAIL fetch_addr_off%0d: got %h expected 0004", off, mem_addr); end
      mem_ack = 1; mem_rdata = 32'h44332211;
      cyc(); mem_ack = 0;
      tests_run++; if ({mbr_load, mbr_data} !== {1'b1, exp_b[off]}) begin tests_failed++; $display("FAIL fetch_byte_off%0d: got load=%b byte=%h expected 1 %h", off, mbr_load, mbr_data, exp_b[off]); end
      $display("[TB] test_fetch: pc=0x%h -> 0x%h", pc, mbr_data);
    end
  endtask

  task automatic test_back_to_back();
    do_reset();
    mar = 32'h20; rd_req = 1; pc = 32'h8; fetch_req = 1;       // t
    cyc(); rd_req = 0; fetch_req = 0;                           // t+1
    tests_run++; if ({mem_req, mem_we, mem_addr} !== {1'b1, 1'b0, 16'h0020}) begin tests_failed++; $display("FAIL b2b_data_first: got req=%b we=%b addr=%h, expected 1 0 0020", mem_req, mem_we, mem_addr); end
    cyc(); mem_ack = 1; mem_rdata = 32'hA5A5A5A5;               // t+2
    cyc(); mem_rdata = 32'h000000CC;                            // t+3, fetch acked at once
    tests_run++; if ({mem_req, mem_addr, mdr_load, mdr_rdata} !== {1'b1, 16'h0002, 1'b1, 32'hA5A5A5A5}) begin tests_failed++; $display("FAIL b2b_fetch_issue: got req=%b addr=%h mdr_load=%b mdr=%h, expected 1 0002 1 a5a5a5a5", mem_req, mem_addr, mdr_load, mdr_rdata); end
    cyc(); mem_ack = 0;                                         // t+4
    tests_run++; if ({mbr_load, mbr_data, mem_req} !== {1'b1, 8'hCC, 1'b0}) begin tests_failed++; $display("FAIL b2b_fetch_done: got load=%b mbr=%h req=%b, expected 1 cc 0", mbr_load, mbr_data, mem_req); end
    $display("[TB] test_back_to_back: data 0x20 then fetch 0x2");
  endtask

  task automatic test_starve();
    do_reset();
    mar = 32'h30; rd_req = 1; pc = 32'h40; fetch_req = 1;      // t
    cyc(); fetch_req = 0; mar = 32'h31; #1;                     // t+1
    tests_run++; if ({stall, mem_req, mem_addr} !== {1'b1, 1'b1, 16'h0030}) begin tests_failed++; $display("FAIL starve_g1: got stall=%b req=%b addr=%h, expected 1 1 0030", stall, mem_req, mem_addr); end
    cyc(); mem_ack = 1; mem_rdata = 32'h1; #1;                  // t+2
    tests_run++; if (stall !== 1'b0) begin tests_failed++; $display("FAIL starve_refill_stall: got %b expected 0", stall); end
    cyc(); mem_ack = 0; mar = 32'h32; #1;                       // t+3
    tests_run++; if ({stall, mem_addr, mdr_load} !== {1'b1, 16'h0031, 1'b1}) begin tests_failed++; $display("FAIL starve_g2: got stall=%b addr=%h mdr_load=%b, expected 1 0031 1", stall, mem_addr, mdr_load); end
    cyc(); mem_ack = 1; mem_rdata = 32'h2; #1;                  // t+4
    tests_run++; if (stall !== 1'b0) begin tests_failed++; $display("FAIL starve_refill2_stall: got %b expected 0", stall); end
    cyc(); rd_req = 0; mem_rdata = 32'h000000AB;                // t+5
    tests_run++; if ({mem_req, mem_addr, mdr_rdata} !== {1'b1, 16'h0010, 32'h2}) begin tests_failed++; $display("FAIL starve_fetch_forced: got req=%b addr=%h mdr=%h, expected 1 0010 00000002", mem_req, mem_addr, mdr_rdata); end
    cyc(); mem_rdata = 32'h3;                                   // t+6
    tests_run++; if ({mbr_load, mbr_data, mem_req, mem_addr} !== {1'b1, 8'hAB, 1'b1, 16'h0032}) begin tests_failed++; $display("FAIL starve_data_after: got mbr_load=%b mbr=%h req=%b addr=%h, expected 1 ab 1 0032", mbr_load, mbr_data, mem_req, mem_addr); end
    cyc(); mem_ack = 0;                                         // t+7
    tests_run++; if ({mdr_load, mdr_rdata, mem_req} !== {1'b1, 32'h3, 1'b0}) begin tests_failed++; $display("FAIL starve_done: got load=%b mdr=%h req=%b, expected 1 00000003 0", mdr_load, mdr_rdata, mem_req); end
    $display("[TB] test_starve: grants 0x30 0x31 fetch 0x32");
  endtask

  task automatic test_rd_wr_err();
    do_reset();
    tests_run++; if (err !== 1'b0) begin tests_failed++; $display("FAIL err_clear: got %b expected 0", err); end
    mar = 32'h50; mdr_wdata = 32'h5; rd_req = 1; wr_req = 1;   // t
    cyc(); rd_req = 0; wr_req = 0;                              // t+1
    tests_run++; if ({mem_req, mem_we, mem_wdata, mem_addr, err} !== {1'b1, 1'b1, 32'h5, 16'h0050, 1'b1}) begin tests_failed++; $display("FAIL rdwr_issue: got req=%b we=%b wdata=%h addr=%h err=%b, expected 1 1 00000005 0050 1", mem_req, mem_we, mem_wdata, mem_addr, err); end
    mem_ack = 1;
    cyc(); mem_ack = 0;                                         // t+2
    tests_run++; if ({mdr_load, mem_req, err} !== 3'b001) begin tests_failed++; $display("FAIL rdwr_no_load: got load=%b req=%b err=%b, expected 0 0 1", mdr_load, mem_req, err); end
    cyc(); cyc();
    tests_run++; if (err !== 1'b1) begin tests_failed++; $display("FAIL err_sticky: got %b expected 1", err); end
    $display("[TB] test_rd_wr_err: write 0x5 to 0x50, err=%b", err);
  endtask

  task automatic test_ack_idle();
    do_reset();
    mem_ack = 1; mem_rdata = 32'h12345678;
    cyc(); mem_ack = 0;
    tests_run++; if ({err, mdr_load, mbr_load, mem_req} !== 4'b1000) begin tests_failed++; $display("FAIL ack_idle: got err=%b mdr_load=%b mbr_load=%b req=%b, expected 1 0 0 0", err, mdr_load, mbr_load, mem_req); end
    $display("[TB] test_ack_idle: stray ack, err=%b", err);
  endtask

  task automatic test_reset_mid();
    do_reset();
    mar = 32'h60; rd_req = 1;                                   // t
    cyc(); rd_req = 0;                                          // t+1
    tests_run++; if (mem_req !== 1'b1) begin tests_failed++; $display("FAIL rstmid_req: got %b expected 1", mem_req); end
    rst = 1;
    cyc();                                                      // t+2
    tests_run++; if (mem_req !== 1'b0) begin tests_failed++; $display("FAIL rstmid_drop: got %b expected 0", mem_req); end
    mem_ack = 1; mem_rdata = 32'h77;
    cyc(); rst = 0; mem_ack = 0;                                // t+3
    tests_run++; if ({mdr_load, err, mem_req} !== 3'b000) begin tests_failed++; $display("FAIL rstmid_discard: got load=%b err=%b req=%b, expected 0 0 0", mdr_load, err, mem_req); end
    mar = 32'h61; rd_req = 1;
    cyc(); rd_req = 0;                                          // t+4
    tests_run++; if ({mem_req, mem_addr} !== {1'b1, 16'h0061}) begin tests_failed++; $display("FAIL rstmid_fresh: got req=%b addr=%h, expected 1 0061", mem_req, mem_addr); end
    mem_ack = 1; mem_rdata = 32'h99;
    cyc(); mem_ack = 0;                                         // t+5
    tests_run++; if ({mdr_load, mdr_rdata} !== {1'b1, 32'h99}) begin tests_failed++; $display("FAIL rstmid_fresh_load: got load=%b mdr=%h, expected 1 00000099", mdr_load, mdr_rdata); end
    $display("[TB] test_reset_mid: fresh read 0x61 -> 0x%h", mdr_rdata);
  endtask

  initial begin
    test_reset();
    test_read();
    test_fetch();
    test_back_to_back();
    test_starve();
    test_rd_wr_err();
    test_ack_idle();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
